// File: rtl/ama_riscv_fetch_buffer_pkg.sv
// Shared constants for the fetch buffer: immediate-generator selects,
// RV32I major opcodes and the canonical NOP.
package ama_riscv_fetch_buffer_pkg;

  localparam logic [3:0] IG_DISABLED = 4'b0000;
  localparam logic [3:0] IG_I_TYPE   = 4'b0001;
  localparam logic [3:0] IG_S_TYPE   = 4'b0010;
  localparam logic [3:0] IG_B_TYPE   = 4'b0011;
  localparam logic [3:0] IG_J_TYPE   = 4'b0100;
  localparam logic [3:0] IG_U_TYPE   = 4'b0101;

  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ama_riscv_fetch_buffer_predecode.sv
// Opcode-to-immediate-select decoder; purely combinational so decode can reuse it.
module ama_riscv_predecode
  import ama_riscv_fetch_buffer_pkg::*;
(
  input  logic [6:0] inst,
  output logic [3:0] ig_sel
);

  always_comb begin
    ig_sel = IG_DISABLED;
    case (inst)
      OPC_ARI_ITYPE, OPC_LOAD, OPC_JALR, OPC_SYSTEM: ig_sel = IG_I_TYPE;
      OPC_STORE:                                     ig_sel = IG_S_TYPE;
      OPC_BRANCH:                                    ig_sel = IG_B_TYPE;
      OPC_JAL:                                       ig_sel = IG_J_TYPE;
      OPC_LUI, OPC_AUIPC:                            ig_sel = IG_U_TYPE;
      default:                                       ig_sel = IG_DISABLED;
    endcase
  end

endmodule

// File: rtl/ama_riscv_fetch_buffer.sv
// Fetch-to-decode FIFO; opcodes are pre-decoded on enqueue so decode sees a ready ig_sel.
// Handshake: a transfer happens on a rising edge where valid && ready; flush overrides both sides.
module ama_riscv_fetch_buffer
  import ama_riscv_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_inst,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [3:0]                 out_ig_sel,
  output logic [24:0]                out_ig_in,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [3:0]      sel_q  [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      in_ig_sel;
  logic            push, pop;

  ama_riscv_predecode u_predecode (
    .inst   (in_inst[6:0]),
    .ig_sel (in_ig_sel)
  );

  // in_ready depends only on occupancy (and flush), never on out_ready.
  assign in_ready  = flush || (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        sel_q[i]  <= IG_DISABLED;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        inst_q[wr_ptr_q] <= in_inst;
        pc_q[wr_ptr_q]   <= in_pc;
        sel_q[wr_ptr_q]  <= in_ig_sel;
      end
    end
  end

  // An empty buffer presents a NOP so decode never sees stale storage.
  always_comb begin
    out_inst   = XLEN'(NOP_INST);
    out_pc     = '0;
    out_ig_sel = IG_DISABLED;
    if (out_valid) begin
      out_inst   = inst_q[rd_ptr_q];
      out_pc     = pc_q[rd_ptr_q];
      out_ig_sel = sel_q[rd_ptr_q];
    end
  end

  assign out_ig_in = out_inst[31:7];

endmodule

// File: tb/tb_ama_riscv_fetch_buffer.sv
// Bench for the fetch buffer: occupancy model plus expected-entry queue,
// table-driven predecode vectors and hand-written corner sequences.
module tb_ama_riscv_fetch_buffer;
  import ama_riscv_fetch_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int W     = 68;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;
  logic [3:0]        out_ig_sel;
  logic [24:0]       out_ig_in;
  logic [1:0]        count;

  int n_tests = 0;
  int n_fail  = 0;

  // {inst, pc, ig_sel}
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  sel;
  } vec_t;
  vec_t vecs[12];

  ama_riscv_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_ig_sel (out_ig_sel),
    .out_ig_in  (out_ig_in),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_count"}, W'(count), W'(0));
    chk({tag, "_out_inst"}, W'(out_inst), W'(32'h0000_0013));
    chk({tag, "_out_pc"}, W'(out_pc), W'(0));
    chk({tag, "_out_ig_sel"}, W'(out_ig_sel), W'(IG_DISABLED));
    chk({tag, "_out_ig_in"}, W'(out_ig_in), W'(25'h0000000));
  endtask

  // Called just after a falling edge: drive, check current outputs, update model, advance one cycle.
  task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [3:0] sel, input logic ordy, input logic fl);
    logic [W-1:0] head;
    logic         exp_ready;
    logic         do_push;
    logic         do_pop;
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_ready = fl || (exp_q.size() < DEPTH);
    chk("in_ready", W'(in_ready), W'(exp_ready));
    chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    chk("count", W'(count), W'(exp_q.size()));
    if (exp_q.size() != 0) head = exp_q[0];
    else head = {NOP_INST, 32'h0, IG_DISABLED};
    chk("out_inst", W'(out_inst), W'(head[67:36]));
    chk("out_pc", W'(out_pc), W'(head[35:4]));
    chk("out_ig_sel", W'(out_ig_sel), W'(head[3:0]));
    chk("out_ig_in", W'(out_ig_in), W'(head[67:43]));
    do_push = iv && exp_ready;
    do_pop  = (exp_q.size() != 0) && ordy;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({inst, pc, sel});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, IG_I_TYPE};   // addi
    vecs[1]  = '{32'h00002083, IG_I_TYPE};   // lw
    vecs[2]  = '{32'h000080E7, IG_I_TYPE};   // jalr
    vecs[3]  = '{32'h00000073, IG_I_TYPE};   // ecall
    vecs[4]  = '{32'h00112623, IG_S_TYPE};   // sw
    vecs[5]  = '{32'h00208463, IG_B_TYPE};   // beq
    vecs[6]  = '{32'h008000EF, IG_J_TYPE};   // jal
    vecs[7]  = '{32'h123450B7, IG_U_TYPE};   // lui
    vecs[8]  = '{32'h00001097, IG_U_TYPE};   // auipc
    vecs[9]  = '{32'h002081B3, IG_DISABLED}; // add
    vecs[10] = '{32'h0000000F, IG_DISABLED}; // fence
    vecs[11] = '{32'h0000007F, IG_DISABLED}; // unused opcode

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First push: 1-cycle latency and pre-split immediate bits.
    cycle(1'b1, 32'h00500093, 32'h0, IG_I_TYPE, 1'b0, 1'b0);
    #1;
    chk("addi_ig_in", W'(out_ig_in), W'(25'h00A001));
    chk("addi_ig_sel", W'(out_ig_sel), W'(IG_I_TYPE));
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    idle();

    // Table: push+pop every cycle at occupancy 1; pointers wrap, PCs stay contiguous.
    for (int i = 0; i < 12; i++)
      cycle(1'b1, vecs[i].inst, 32'(i * 4), vecs[i].sel, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    idle();

    // Backpressure: sw, beq fill the buffer, jal is held off.
    cycle(1'b1, 32'h00112623, 32'h100, IG_S_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208463, 32'h104, IG_B_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 32'h108, IG_J_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 32'h108, IG_J_TYPE, 1'b0, 1'b0);
    // Full with both sides active: only the pop happens.
    cycle(1'b1, 32'h008000EF, 32'h108, IG_J_TYPE, 1'b1, 1'b0);
    cycle(1'b1, 32'h008000EF, 32'h108, IG_J_TYPE, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    idle();

    // Flush at count=2 with push and pop requested; flush-cycle instruction is dropped.
    cycle(1'b1, 32'h00500093, 32'h200, IG_I_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h00112623, 32'h204, IG_S_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 32'h208, IG_J_TYPE, 1'b1, 1'b1);
    idle();
    cycle(1'b1, 32'h123450B7, 32'h300, IG_U_TYPE, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-stream with count=2.
    cycle(1'b1, 32'h00208463, 32'h400, IG_B_TYPE, 1'b0, 1'b0);
    cycle(1'b1, 32'h00001097, 32'h404, IG_U_TYPE, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h002081B3, 32'h500, IG_DISABLED, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000073, 32'h504, IG_I_TYPE, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, IG_DISABLED, 1'b1, 1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_fetch_buffer.md
Name: ama_riscv_fetch_buffer

Overview:
- Registered instruction buffer between IMEM fetch and decode.
- Queues fetched {instruction, PC} pairs in a small FIFO and pre-decodes each instruction's opcode into an immediate-generator select at enqueue time.
- Presents the head entry to decode with the instruction bits already split for the immediate generator, which removes opcode decoding from the ID critical path.
- Supports valid/ready backpressure on both sides and a single-cycle flush for branch/jump redirects.

Parameters:
DEPTH, 2, FIFO entries; power of 2, ≥2
XLEN, 32, PC and instruction width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  buffer can accept; equals count<DEPTH, independent of out_ready
in_inst  input  XLEN  fetched instruction
in_pc  input  XLEN  PC of in_inst
flush  input  1  synchronous redirect; discards all entries
out_valid  output  1  head entry valid; equals count!=0
out_ready  input  1  decode consumes head
out_inst  output  XLEN  head instruction
out_pc  output  XLEN  head PC
out_ig_sel  output  4  pre-decoded immediate select for head
out_ig_in  output  25  head instruction bits [31:7]
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): count=0; read/write pointers=0; all storage cleared.
  - During and after reset: out_valid=0, in_ready=1.
  - out_inst=32'h0000_0013 (NOP), out_pc=0, out_ig_sel=`IG_DISABLED, out_ig_in=NOP[31:7].
- Push: in_valid && in_ready at a rising edge.
  - Writes {in_inst, in_pc, predecode(in_inst[6:0])} to the write pointer and increments the write pointer.
- Pop: out_valid && out_ready at a rising edge; increments the read pointer.
- Occupancy: count +1 on push only, −1 on pop only, unchanged when both occur.
- Full: in_ready=0. A simultaneous pop does not open a push slot in the same cycle; in_ready has no combinational path from out_ready.
- Empty: out_valid=0. No bypass; an entry pushed at edge N is visible on the outputs after edge N (1-cycle latency).
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Outputs are a mux of the head entry. When out_valid=0 they take the NOP/default values listed under reset. Outputs are stable while out_valid && !out_ready.
- flush has highest priority:
  - At the edge: count=0 and both pointers=0.
  - A push or pop in the same cycle is ignored; the in_inst of that cycle is dropped.
  - Stored data need not be cleared.
  - in_ready stays 1 during flush.
- Pre-decode on opcode bits [6:0]:
  - 0010011, 0000011, 1100111, 1110011 → `IG_I_TYPE
  - 0100011 → `IG_S_TYPE
  - 1100011 → `IG_B_TYPE
  - 1101111 → `IG_J_TYPE
  - 0110111, 0010111 → `IG_U_TYPE
  - 0110011 and all other opcodes → `IG_DISABLED
- Reset asserted mid-operation returns every state element to its reset value immediately. In-flight entries are lost.

Decomposition:
- Shared ama_riscv_defines.v:
  - `IG_I_TYPE, `IG_S_TYPE, `IG_B_TYPE, `IG_J_TYPE, `IG_U_TYPE (existing)
  - new `IG_DISABLED=4'b0000
  - opcode constants: `OPC_ARI_ITYPE, `OPC_LOAD, `OPC_JALR, `OPC_SYSTEM, `OPC_STORE, `OPC_BRANCH, `OPC_JAL, `OPC_LUI, `OPC_AUIPC, `OPC_ARI_RTYPE
  - `NOP_INST=32'h0000_0013
- Sub-module ama_riscv_predecode: combinational, in inst[6:0], out ig_sel[3:0]. Unit-testable alone and reusable by decode.

Test Plan:
- Reset, then push in_inst=32'h00500093 (addi), in_pc=0 at edge 1 → after edge 1: out_valid=1, out_ig_sel=`IG_I_TYPE, out_ig_in=25'h00A001, count=1.
- Push sw 32'h00112623, beq 32'h00208463, jal 32'h008000EF with out_ready=0 (DEPTH=2) → first two accepted, in_ready=0, count=2, jal held off. Then out_ready=1 → pops in order: ig_sel S then B, then J.
- Full FIFO with in_valid=1 and out_ready=1 in one cycle → only the pop occurs, count 2→1; push is accepted next cycle.
- Occupancy 1 with push+pop same edge, repeated 8 cycles → count stays 1; pointers wrap 1→0 with no data loss or reorder; PCs 0,4,8,… emerge contiguous.
- Count=2, then flush=1 with in_valid=1 and out_ready=1 → after the edge: count=0, out_valid=0, out_inst=32'h00000013, out_ig_sel=`IG_DISABLED; the flush-cycle instruction never appears.
- rst_n dropped mid-stream between edges with count=2 → outputs go to reset values asynchronously; after release the first push lands at pointer 0.
